bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter sharing the single system bus between four bus masters (CPU I-fetch, CPU data, DMA, debug).
- Sits upstream of the address decoder and slave mux. The granted master's address and control drive the shared bus.
- The slave-select decoder then selects one of 8 slaves from s_addr[31:29].
- Grant is held for as long as the owner keeps its request asserted. This gives locked multi-cycle transfers.

Parameters:
- MAX_HOLD, 16: cycles an owner may hold the bus before forced rotation. Only used with BUS_ARB_TIMEOUT_EN. Legal range 2..255.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- m0_req  input  1  master 0 bus request
- m1_req  input  1  master 1 bus request
- m2_req  input  1  master 2 bus request
- m3_req  input  1  master 3 bus request
- m0_grnt  output  1  master 0 bus grant (registered)
- m1_grnt  output  1  master 1 bus grant (registered)
- m2_grnt  output  1  master 2 bus grant (registered)
- m3_grnt  output  1  master 3 bus grant (registered)
- bus_owner  output  2  index of current/last owner; steers the master-to-bus mux
- bus_busy  output  1  `YES while any grant is asserted

Interface decision: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset (rst high at an edge):
  - all mN_grnt = `NO; bus_busy = `NO; bus_owner = 2'd3; state = ST_IDLE.
  - Because bus_owner resets to 3, master 0 has first priority after reset.
  - Reset mid-transfer drops the grant on that same edge; no completion is owed.
- Grant invariant: at most one mN_grnt high in any cycle. bus_busy = OR of all grants.
- Round-robin pick: search order is bus_owner+1, +2, +3, +4, all mod 4. The first requester in that order wins. The current owner is therefore lowest priority.
- State ST_IDLE:
  - No grants.
  - If any req is sampled high at an edge: the grant for the picked master goes high on that edge; bus_owner = picked; state -> ST_OWNED.
  - Latency: request seen at edge N, grant visible after edge N.
- State ST_OWNED:
  - Owner's req high: hold the grant, bus_owner unchanged.
  - Owner's req sampled low at an edge:
    - Other requesters present: on the same edge the old grant drops and the picked new grant rises. Zero-bubble handover; state stays ST_OWNED.
    - No requesters: all grants drop, state -> ST_IDLE, bus_owner retains the last owner.
- Simultaneous events:
  - Owner drops req while others raise req in the same cycle: direct handover per the rule above.
  - A released owner that re-asserts req on the following cycle is lowest priority.
  - A req pulse shorter than one cycle that is not sampled at an edge is ignored.
- No deadlock: a requester waits at most 3 ownership periods.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit hold_cnt clears on every new grant and increments each cycle in ST_OWNED.
  - When hold_cnt == MAX_HOLD-1 and any other master is requesting, the next edge forces rotation to the picked master, even though the owner's req is still high.
  - If no other master is requesting, the owner keeps the grant and hold_cnt saturates at MAX_HOLD-1.
  - The preempted master re-requests through the normal round-robin order.
- Without the macro: no counter exists and the owner holds the bus indefinitely.

Decomposition:
- Additions to defines.v:
  - `BusOwnerBus [1:0]
  - `BUS_OWNER_M0..`BUS_OWNER_M3 (2'd0..2'd3)
  - `ARB_ST_IDLE / `ARB_ST_OWNED encodings
  - `ArbStateBus
- Existing `YES/`NO are reused.
- One natural sub-module: bus_arb_rr_pick.
  - Purely combinational.
  - Inputs: req[3:0] and last owner. Outputs: valid and pick[1:0].
  - Used for both initial grant and handover.

Test Plan:
- Reset release with m0_req=m2_req=1 at the same edge -> m0_grnt=1 one cycle later; bus_owner=0; bus_busy=1.
- m0 holds req for 5 cycles, then drops it while m2_req=1 -> on that edge m0_grnt=0 and m2_grnt=1 simultaneously, no idle cycle; bus_owner=2.
- All four reqs held high continuously; each owner drops req after 1 cycle of grant -> grant sequence 0,1,2,3,0; never two grants high.
- m1 sole requester drops req -> next edge all grants 0, bus_busy=0, bus_owner stays 1. Then m1 and m3 request together -> m3 is granted (search order 2,3,0,1).
- rst asserted while m2_grnt=1 -> grants 0 after that edge; after release with m2_req=m3_req=1 -> m2 granted (owner reset to 3).
- BUS_ARB_TIMEOUT_EN, MAX_HOLD=4: m0 holds req while m1 requests -> m0_grnt high exactly 4 cycles, then m1_grnt=1. Repeat with m1 idle -> m0 keeps the grant past 4 cycles.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the four-master round-robin bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned NUM_MASTERS = 4;

  localparam logic YES = 1'b1;
  localparam logic NO  = 1'b0;

  typedef logic [1:0] owner_t;

  localparam owner_t BUS_OWNER_M0 = 2'd0;
  localparam owner_t BUS_OWNER_M1 = 2'd1;
  localparam owner_t BUS_OWNER_M2 = 2'd2;
  localparam owner_t BUS_OWNER_M3 = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  function automatic logic [NUM_MASTERS-1:0] owner_onehot(input owner_t owner);
    return 4'b0001 << owner;
  endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin picker: searches last+1 .. last+4 (mod 4), first requester wins.
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  owner_t                 last,
  output logic                   valid,
  output owner_t                 pick
);

  owner_t idx;

  always_comb begin
    valid = NO;
    pick  = last;
    idx   = last;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = last + 2'(i);
      if (!valid && req[idx]) begin
        valid = YES;
        pick  = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for four masters with locked transfers and zero-bubble handover.
// Optional forced rotation after MAX_HOLD cycles when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic       m3_req,
  output logic       m0_grnt,
  output logic       m1_grnt,
  output logic       m2_grnt,
  output logic       m3_grnt,
  output logic [1:0] bus_owner,
  output logic       bus_busy
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must be in 2..255");
  end

  arb_state_t             state, state_next;
  logic [NUM_MASTERS-1:0] grant, grant_next;
  owner_t                 owner, owner_next;
  logic [NUM_MASTERS-1:0] req_all, pick_req;
  logic                   pick_valid;
  owner_t                 pick;
  logic                   owner_req;
  logic                   new_grant;
  logic                   force_rotate;

  assign req_all   = {m3_req, m2_req, m1_req, m0_req};
  assign owner_req = req_all[owner];

  // While owned, the owner is masked so a valid pick always means "someone else is waiting".
  assign pick_req = (state == ST_OWNED) ? (req_all & ~owner_onehot(owner)) : req_all;

  bus_arb_rr_pick u_pick (
    .req   (pick_req),
    .last  (owner),
    .valid (pick_valid),
    .pick  (pick)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;

  assign force_rotate = (hold_cnt == HOLD_LAST) && pick_valid;

  always_ff @(posedge clk) begin
    if (rst || new_grant) begin
      hold_cnt <= '0;
    end else if (state == ST_OWNED && hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign force_rotate = NO;
`endif

  always_comb begin
    state_next = state;
    grant_next = grant;
    owner_next = owner;
    new_grant  = NO;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_next = owner_onehot(pick);
          owner_next = pick;
          state_next = ST_OWNED;
          new_grant  = YES;
        end
      end
      ST_OWNED: begin
        if (owner_req && !force_rotate) begin
          grant_next = grant;
        end else if (pick_valid) begin
          grant_next = owner_onehot(pick);
          owner_next = pick;
          new_grant  = YES;
        end else begin
          grant_next = '0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        grant_next = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      grant <= '0;
      owner <= BUS_OWNER_M3;
    end else begin
      state <= state_next;
      grant <= grant_next;
      owner <= owner_next;
    end
  end

  assign m0_grnt   = grant[BUS_OWNER_M0];
  assign m1_grnt   = grant[BUS_OWNER_M1];
  assign m2_grnt   = grant[BUS_OWNER_M2];
  assign m3_grnt   = grant[BUS_OWNER_M3];
  assign bus_owner = owner;
  assign bus_busy  = |grant;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, scoreboard queue, hand-written corner sequences.
module tb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic       m0_req, m1_req, m2_req, m3_req;
  logic       m0_grnt, m1_grnt, m2_grnt, m3_grnt;
  logic [1:0] bus_owner;
  logic       bus_busy;

  int compared = 0;
  int mismatched = 0;
  logic started = 1'b0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] exp_q[$];

  bus_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m1_req    (m1_req),
    .m2_req    (m2_req),
    .m3_req    (m3_req),
    .m0_grnt   (m0_grnt),
    .m1_grnt   (m1_grnt),
    .m2_grnt   (m2_grnt),
    .m3_grnt   (m3_grnt),
    .bus_owner (bus_owner),
    .bus_busy  (bus_busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant invariant: one-hot-or-zero grants, busy is their OR
  always @(negedge clk) begin
    logic [3:0] g;
    g = {m3_grnt, m2_grnt, m1_grnt, m0_grnt};
    if (started) begin
      compared++;
      if ($countones(g) > 1 || bus_busy !== (|g)) begin
        mismatched++;
        $display("FAIL invariant t=%0t grants=%b busy=%b required at most one grant and busy=OR", $time, g, bus_busy);
      end
    end
  end

  function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] g,
                              input logic [1:0] o, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.grant = g; v.owner = o; v.busy = b;
    vecs.push_back(v);
  endfunction

  task automatic check_out(input string name);
    logic [6:0] exp;
    logic [6:0] act;
    act = {m3_grnt, m2_grnt, m1_grnt, m0_grnt, bus_owner, bus_busy};
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL %s: no expectation queued, got grant=%b owner=%0d busy=%b", name, act[6:3], act[2:1], act[0]);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        mismatched++;
        $display("FAIL %s: got grant=%b owner=%0d busy=%b, required grant=%b owner=%0d busy=%b",
                 name, act[6:3], act[2:1], act[0], exp[6:3], exp[2:1], exp[0]);
      end
    end
  endtask

  // Driver: apply inputs mid-cycle, expectation checked just after the next rising edge
  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] g,
                      input logic [1:0] o, input logic b, input string name);
    @(negedge clk);
    rst = r;
    {m3_req, m2_req, m1_req, m0_req} = q;
    exp_q.push_back({g, o, b});
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  initial begin
    rst = 1'b1;
    {m3_req, m2_req, m1_req, m0_req} = 4'b0000;

    //   rst   req      grant    own busy
    add(1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0);  // reset state
    add(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1);  // m0 first after reset
    add(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);  // zero-bubble handover to m2
    add(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);  // idle keeps last owner
    add(1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0);
    add(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1);  // rotation 0,1,2,3,0
    add(1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1);
    add(1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1);
    add(1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1);
    add(1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1);  // m1 sole requester
    add(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0);
    add(1'b0, 4'b1010, 4'b1000, 2'd3, 1'b1);  // m1+m3 from owner 1 -> m3
    add(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
    add(1'b1, 4'b0100, 4'b0000, 2'd3, 1'b0);  // reset mid-transfer
    add(1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1);  // m2 beats m3 after reset
    add(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0);
    add(1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1);  // released m3 loses to m0
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);

    @(posedge clk);
    started = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].grant, vecs[i].owner, vecs[i].busy,
           $sformatf("vec%0d", i));
    end

    // Sub-cycle pulse on m1 between edges must be ignored
    @(negedge clk);
    #2 m1_req = 1'b1;
    #2 m1_req = 1'b0;
    exp_q.push_back({4'b0000, 2'd0, 1'b0});
    @(posedge clk);
    #1;
    check_out("short_pulse");

    // m0 owns while m1 waits
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, "hold_start");
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, $sformatf("hold%0d", i));
    step(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, "forced_rotate");
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, "reacquire_m0");
    for (int i = 0; i < 8; i++) step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, $sformatf("saturate%0d", i));
`else
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, $sformatf("locked%0d", i));
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, "release_to_m1");
`endif
    step(1'b0, 4'b0000, 4'b0000, (`ifdef BUS_ARB_TIMEOUT_EN 2'd0 `else 2'd1 `endif), 1'b0, "final_idle");

    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL leftover: %0d expectations never compared, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
